// File: rtl/ode_matvec_fetch_ctrl.sv
// Read sequencer for matrix-vector products: walks an N x N row-major matrix and a
// length-N vector over two read-only RAM ports and streams element pairs downstream.
module ode_matvec_fetch_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int M_ADDR_WIDTH = 12,
  parameter int V_ADDR_WIDTH = 10,
  parameter int N_WIDTH      = 6,
  parameter int MAX_N        = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_WIDTH-1:0]      n,
  input  logic [V_ADDR_WIDTH-1:0] v_base,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [M_ADDR_WIDTH-1:0] m_addr,
  output logic                    m_we,
  output logic [V_ADDR_WIDTH-1:0] v_addr,
  output logic                    v_we,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [DATA_WIDTH-1:0]   v_rdata,
  output logic [DATA_WIDTH-1:0]   out_m,
  output logic [DATA_WIDTH-1:0]   out_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_WIDTH-1:0]      out_row,
  output logic [N_WIDTH-1:0]      out_col,
  output logic                    out_row_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [N_WIDTH-1:0]      r_n;
  logic [N_WIDTH-1:0]      r_i;
  logic [N_WIDTH-1:0]      r_j;
  logic [V_ADDR_WIDTH-1:0] r_v_base;
  logic [M_ADDR_WIDTH-1:0] r_m_addr;
  logic [V_ADDR_WIDTH-1:0] r_v_addr;
  logic [M_ADDR_WIDTH-1:0] r_cur_m_addr;
  logic [V_ADDR_WIDTH-1:0] r_cur_v_addr;
  logic                    r_out_valid;
  logic [N_WIDTH-1:0]      r_out_row;
  logic [N_WIDTH-1:0]      r_out_col;
  logic                    r_row_last;
  logic                    r_done;
  logic                    r_err;

  logic w_advance;
  logic w_stall;
  logic w_legal_n;
  logic w_last_col;
  logic w_last_beat;

  assign w_advance   = !r_out_valid || out_ready;
  assign w_stall     = r_out_valid && !out_ready;
  assign w_legal_n   = (n != '0) && (n <= N_WIDTH'(MAX_N));
  assign w_last_col  = (r_j == r_n - N_WIDTH'(1));
  assign w_last_beat = w_last_col && (r_i == r_n - N_WIDTH'(1));

  // The address registers already point at the next pair once a beat is out, so a
  // stalled beat replays its own address to keep the registered RAM output frozen.
  assign m_addr = w_stall ? r_cur_m_addr : r_m_addr;
  assign v_addr = w_stall ? r_cur_v_addr : r_v_addr;

  assign m_we         = 1'b0;
  assign v_we         = 1'b0;
  assign out_m        = m_rdata;
  assign out_v        = v_rdata;
  assign out_valid    = r_out_valid;
  assign out_row      = r_out_row;
  assign out_col      = r_out_col;
  assign out_row_last = r_row_last;
  assign done         = r_done;
  assign err          = r_err;
  assign busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_v_base     <= '0;
      r_m_addr     <= '0;
      r_v_addr     <= '0;
      r_cur_m_addr <= '0;
      r_cur_v_addr <= '0;
      r_out_valid  <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_row_last   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: pulses default low here so every branch below only has to raise them.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_legal_n) begin
              r_err <= 1'b1;
            end else begin
              r_n      <= n;
              r_v_base <= v_base;
              r_m_addr <= '0;
              r_v_addr <= v_base;
              r_i      <= '0;
              r_j      <= '0;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_advance) begin
            r_out_valid  <= 1'b1;
            r_out_row    <= r_i;
            r_out_col    <= r_j;
            r_row_last   <= w_last_col;
            r_cur_m_addr <= r_m_addr;
            r_cur_v_addr <= r_v_addr;
            if (w_last_beat) begin
              r_state <= S_DRAIN;
            end else begin
              r_m_addr <= r_m_addr + M_ADDR_WIDTH'(1);
              if (w_last_col) begin
                r_j      <= '0;
                r_i      <= r_i + N_WIDTH'(1);
                r_v_addr <= r_v_base;
              end else begin
                r_j      <= r_j + N_WIDTH'(1);
                r_v_addr <= r_v_addr + V_ADDR_WIDTH'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_row_last  <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ode_matvec_fetch_ctrl.md
Name: ode_matvec_fetch_ctrl

Overview:
- Read sequencer for the solver's matrix-vector products.
- Walks an N x N row-major matrix in the A or B bank (12-bit port) while stepping a length-N vector in the U/X bank (10-bit port), one element pair per beat.
- Presents the pairs to the downstream MAC through a valid/ready stream, with row/column tags and a row-last flag.
- Owns the read side of both RAM ports while busy and never writes.

Parameters:
- DATA_WIDTH, 64, word width of both RAM ports.
- M_ADDR_WIDTH, 12, matrix bank address width.
- V_ADDR_WIDTH, 10, vector bank address width.
- N_WIDTH, 6, width of the dimension and index fields.
- MAX_N, 50, largest legal N.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- n  in  N_WIDTH  matrix dimension; sampled with start.
- v_base  in  V_ADDR_WIDTH  vector base address; sampled with start.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  one-cycle pulse when start carries an illegal n.
- m_addr  out  M_ADDR_WIDTH  matrix bank address (registered).
- m_we  out  1  matrix bank write enable, constant 0.
- v_addr  out  V_ADDR_WIDTH  vector bank address (registered).
- v_we  out  1  vector bank write enable, constant 0.
- m_rdata  in  DATA_WIDTH  matrix bank read data (1-cycle registered read).
- v_rdata  in  DATA_WIDTH  vector bank read data (1-cycle registered read).
- out_m  out  DATA_WIDTH  matrix element, pass-through of m_rdata.
- out_v  out  DATA_WIDTH  vector element, pass-through of v_rdata.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_row  out  N_WIDTH  row index i of the current beat.
- out_col  out  N_WIDTH  column index j of the current beat.
- out_row_last  out  1  high when j == N-1.

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE.
  - busy, done, err, out_valid, out_row_last = 0.
  - m_addr, v_addr, out_row, out_col = 0.
  - Reset mid-run abandons the sequence; no done pulse follows.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with n == 0 or n > MAX_N: err = 1 for one cycle, remain IDLE.
  - start with legal n: latch n and v_base, set m_addr = 0, v_addr = v_base, i = j = 0, go to ISSUE.
  - start in any other state is ignored.
- advance = !out_valid || out_ready, evaluated every cycle in ISSUE and DRAIN.
- ISSUE, on an edge with advance = 1, the current address pair is issued:
  - out_valid <= 1.
  - out_row/out_col <= issued (i, j); out_row_last <= (j == n-1).
  - Addresses step to the next pair.
    - j < n-1: j+1, m_addr+1, v_addr+1.
    - j == n-1: j = 0, i+1, m_addr+1, v_addr = v_base.
  - m_addr is a running counter (i*n + j); no multiplier.
  - After issuing (n-1, n-1), go to DRAIN; addresses hold.
- Stall: with advance = 0, addresses and tags hold.
  - The RAM re-reads the same address, so out_m/out_v stay stable.
  - No beat is lost or duplicated.
- DRAIN:
  - out_valid && out_ready: out_valid <= 0, go to DONE.
- DONE: done = 1 for one cycle, busy = 0, then IDLE.
- Latency:
  - start accepted at edge E0; first out_valid after E1.
  - With out_ready held 1: n*n beats on consecutive cycles, done high after edge E(n*n+2).
- out_m/out_v are don't-care while out_valid = 0.
- m_we/v_we are 0 at all times, including during reset.

Test Plan:
- n=2, v_base=100, out_ready=1:
  - Beats on 4 consecutive cycles.
  - m_addr sequence 0,1,2,3; v_addr sequence 100,101,100,101.
  - (row,col) (0,0),(0,1),(1,0),(1,1); out_row_last on beats 2 and 4.
  - done after E6.
- n=3, out_ready low for 3 cycles on beat 4:
  - out_m/out_v/out_row/out_col frozen during the stall.
  - Exactly 9 beats total; done once.
- n=0, then n=51:
  - err pulses once each; busy stays 0; no out_valid.
- n=50, v_base=0, random out_ready:
  - 2500 beats; final m_addr 2499; last beat (49,49) with row_last.
- start pulsed while busy (n=2 run):
  - Ignored; the sequence completes unchanged with 4 beats.
- rst_n low during beat 5 of an n=3 run:
  - All outputs 0 immediately, no done pulse.
  - After release, a new start with n=1 gives 1 beat and done.
